sal_wdata_packer: RTL and testbench

//  Upstream feeder of the SAL write-data FIFO. Packs narrow write beats (valid/ready, with last)

---
 rtl/sal_wdata_packer_if.sv | 28 ++
 rtl/sal_wdata_packer.sv | 93 +++++++++
 tb/tb_sal_wdata_packer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sal_wdata_packer_if.sv
// Write-beat input and FIFO write-side bundle for sal_wdata_packer.
// The slave modport is the packer; the master modport is the beat source / FIFO side.
interface sal_wdata_packer_if #(
    parameter int IN_WIDTH  = 32,
    parameter int RATIO_LG2 = 2
);
    localparam int RATIO  = 1 << RATIO_LG2;
    localparam int WORD_W = RATIO + RATIO * IN_WIDTH;

    logic                valid_i;
    logic                ready_o;
    logic [IN_WIDTH-1:0] data_i;
    logic                last_i;
    logic                fifo_full_i;
    logic                fifo_wren_o;
    logic [WORD_W-1:0]   fifo_wdata_o;
    logic                busy_o;

    modport slave (
        input  valid_i, data_i, last_i, fifo_full_i,
        output ready_o, fifo_wren_o, fifo_wdata_o, busy_o
    );

    modport master (
        output valid_i, data_i, last_i, fifo_full_i,
        input  ready_o, fifo_wren_o, fifo_wdata_o, busy_o
    );
endinterface

// File: rtl/sal_wdata_packer.sv
// Packs narrow valid/ready write beats into full-width FIFO words with a per-lane valid mask.
// A single output register decouples assembly from the FIFO; it never writes while the FIFO is full.
module sal_wdata_packer #(
    parameter int IN_WIDTH  = 32,
    parameter int RATIO_LG2 = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sal_wdata_packer_if.slave       bus
);
    localparam int RATIO  = 1 << RATIO_LG2;
    localparam int DATA_W = RATIO * IN_WIDTH;
    localparam int WORD_W = RATIO + DATA_W;
    localparam logic [RATIO_LG2-1:0] LAST_IDX = RATIO_LG2'(RATIO - 1);

    logic [RATIO_LG2-1:0] idx_q,      idx_d;
    logic [DATA_W-1:0]    asm_data_q, asm_data_d;
    logic [RATIO-1:0]     asm_mask_q, asm_mask_d;
    logic                 out_vld_q,  out_vld_d;
    logic [WORD_W-1:0]    out_word_q, out_word_d;

    logic                 ready;
    logic                 wren;
    logic                 accept;
    logic                 complete;
    logic [DATA_W-1:0]    fill_data;
    logic [RATIO-1:0]     fill_mask;

    // ready depends only on the output register and fifo_full_i, never on valid_i.
    assign ready    = ~out_vld_q | ~bus.fifo_full_i;
    assign wren     = out_vld_q & ~bus.fifo_full_i;
    assign accept   = bus.valid_i & ready;
    assign complete = accept & ((idx_q == LAST_IDX) | bus.last_i);

    assign bus.ready_o      = ready;
    assign bus.fifo_wren_o  = wren;
    assign bus.fifo_wdata_o = out_word_q;
    assign bus.busy_o       = out_vld_q | (asm_mask_q != '0);

    always_comb begin
        // NOTE: every variable gets a default first so no path through this block infers a latch.
        idx_d      = idx_q;
        asm_data_d = asm_data_q;
        asm_mask_d = asm_mask_q;
        out_vld_d  = out_vld_q;
        out_word_d = out_word_q;

        fill_data = asm_data_q;
        fill_data[idx_q*IN_WIDTH +: IN_WIDTH] = bus.data_i;
        fill_mask = asm_mask_q;
        fill_mask[idx_q] = 1'b1;

        if (wren) begin
            out_vld_d = 1'b0;
        end

        if (accept) begin
            if (complete) begin
                // A completion in the same cycle as a drain replaces the word and keeps out_vld set.
                out_word_d = {fill_mask, fill_data};
                out_vld_d  = 1'b1;
                idx_d      = '0;
                asm_data_d = '0;
                asm_mask_d = '0;
            end else begin
                idx_d      = idx_q + 1'b1;
                asm_data_d = fill_data;
                asm_mask_d = fill_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            asm_data_q <= '0;
            asm_mask_q <= '0;
            out_vld_q  <= 1'b0;
            out_word_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            idx_q      <= idx_d;
            asm_data_q <= asm_data_d;
            asm_mask_q <= asm_mask_d;
            out_vld_q  <= out_vld_d;
            out_word_q <= out_word_d;
        end
    end

    no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.fifo_wren_o && bus.fifo_full_i));

endmodule

// File: tb/tb_sal_wdata_packer.sv
// Directed bench for sal_wdata_packer: table-driven single-cycle vectors plus
// hand-written sequences for FIFO backpressure and asynchronous mid-word reset.
module tb_sal_wdata_packer;
    localparam int IN_WIDTH  = 32;
    localparam int RATIO_LG2 = 2;
    localparam int WORD_W    = 4 + 4 * IN_WIDTH;
    localparam int NVEC      = 24;

    typedef struct {
        logic                valid;
        logic [IN_WIDTH-1:0] data;
        logic                last;
        logic                full;
        logic                exp_ready;
        logic                exp_wren;
        logic [WORD_W-1:0]   exp_wdata;
        logic                exp_busy;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    vec_t vecs [NVEC];

    sal_wdata_packer_if #(.IN_WIDTH(IN_WIDTH), .RATIO_LG2(RATIO_LG2)) bus ();

    sal_wdata_packer #(.IN_WIDTH(IN_WIDTH), .RATIO_LG2(RATIO_LG2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [WORD_W-1:0] mk(input logic [3:0] m, input logic [31:0] l3,
                                             input logic [31:0] l2, input logic [31:0] l1,
                                             input logic [31:0] l0);
        return {m, l3, l2, l1, l0};
    endfunction

    function automatic vec_t mkv(input logic v, input logic [31:0] d, input logic l,
                                 input logic f, input logic er, input logic ew,
                                 input logic [WORD_W-1:0] ed, input logic eb);
        vec_t r;
        r.valid = v;  r.data = d;  r.last = l;  r.full = f;
        r.exp_ready = er;  r.exp_wren = ew;  r.exp_wdata = ed;  r.exp_busy = eb;
        return r;
    endfunction

    task automatic check(input string name, input logic [WORD_W-1:0] act,
                         input logic [WORD_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic er, input logic ew,
                              input logic [WORD_W-1:0] ed, input logic eb);
        check({tag, ".ready"}, WORD_W'(bus.ready_o),     WORD_W'(er));
        check({tag, ".wren"},  WORD_W'(bus.fifo_wren_o), WORD_W'(ew));
        check({tag, ".wdata"}, bus.fifo_wdata_o,         ed);
        check({tag, ".busy"},  WORD_W'(bus.busy_o),      WORD_W'(eb));
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic f);
        bus.valid_i     = v;
        bus.data_i      = d;
        bus.last_i      = l;
        bus.fifo_full_i = f;
    endtask

    // Drive for one cycle without checking; returns at posedge+1.
    task automatic beat(input logic v, input logic [31:0] d, input logic l, input logic f);
        drive(v, d, l, f);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WORD_W-1:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
        n_cmp = 0;
        n_err = 0;

        w0 = mk(4'hF, 32'h44, 32'h33, 32'h22, 32'h11);
        w1 = mk(4'h3, 32'h0, 32'h0, 32'hB, 32'hA);
        w2 = mk(4'h1, 32'h0, 32'h0, 32'h0, 32'h5);
        w3 = mk(4'hF, 32'h104, 32'h103, 32'h102, 32'h101);
        w4 = mk(4'hF, 32'h108, 32'h107, 32'h106, 32'h105);
        w5 = mk(4'h1, 32'h0, 32'h0, 32'h0, 32'h31);
        w6 = mk(4'h1, 32'h0, 32'h0, 32'h0, 32'h32);
        w7 = mk(4'hF, 32'h24, 32'h23, 32'h22, 32'h21);
        w8 = mk(4'hF, 32'h54, 32'h53, 32'h52, 32'h51);

        //               v     data    l     f     rdy   wren  wdata busy
        vecs[0]  = mkv(1'b1, 32'h11,  1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        vecs[1]  = mkv(1'b1, 32'h22,  1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
        vecs[2]  = mkv(1'b1, 32'h33,  1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
        vecs[3]  = mkv(1'b1, 32'h44,  1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1);
        vecs[4]  = mkv(1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, w0, 1'b1);
        vecs[5]  = mkv(1'b1, 32'hA,   1'b0, 1'b0, 1'b1, 1'b0, w0, 1'b0);
        vecs[6]  = mkv(1'b1, 32'hB,   1'b1, 1'b0, 1'b1, 1'b0, w0, 1'b1);
        vecs[7]  = mkv(1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, w1, 1'b1);
        vecs[8]  = mkv(1'b1, 32'h5,   1'b1, 1'b0, 1'b1, 1'b0, w1, 1'b0);
        vecs[9]  = mkv(1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, w2, 1'b1);
        vecs[10] = mkv(1'b1, 32'h101, 1'b0, 1'b0, 1'b1, 1'b0, w2, 1'b0);
        vecs[11] = mkv(1'b1, 32'h102, 1'b0, 1'b0, 1'b1, 1'b0, w2, 1'b1);
        vecs[12] = mkv(1'b1, 32'h103, 1'b0, 1'b0, 1'b1, 1'b0, w2, 1'b1);
        vecs[13] = mkv(1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 1'b0, w2, 1'b1);
        vecs[14] = mkv(1'b1, 32'h105, 1'b0, 1'b0, 1'b1, 1'b1, w3, 1'b1);
        vecs[15] = mkv(1'b1, 32'h106, 1'b0, 1'b0, 1'b1, 1'b0, w3, 1'b1);
        vecs[16] = mkv(1'b1, 32'h107, 1'b0, 1'b0, 1'b1, 1'b0, w3, 1'b1);
        vecs[17] = mkv(1'b1, 32'h108, 1'b0, 1'b0, 1'b1, 1'b0, w3, 1'b1);
        vecs[18] = mkv(1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, w4, 1'b1);
        vecs[19] = mkv(1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, w4, 1'b0);
        vecs[20] = mkv(1'b1, 32'h31,  1'b1, 1'b0, 1'b1, 1'b0, w4, 1'b0);
        vecs[21] = mkv(1'b1, 32'h32,  1'b1, 1'b0, 1'b1, 1'b1, w5, 1'b1);
        vecs[22] = mkv(1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, w6, 1'b1);
        vecs[23] = mkv(1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, w6, 1'b0);

        // Reset values, checked before any clock edge.
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        check_outs("reset", 1'b1, 1'b0, '0, 1'b0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full, partial, single-beat, back-to-back and drain-plus-complete words.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].full);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_wren,
                       vecs[i].exp_wdata, vecs[i].exp_busy);
            @(posedge clk);
            #1;
        end

        // Backpressure: a pending word with the FIFO full blocks every beat.
        beat(1'b1, 32'h21, 1'b0, 1'b0);
        beat(1'b1, 32'h22, 1'b0, 1'b0);
        beat(1'b1, 32'h23, 1'b0, 1'b0);
        beat(1'b1, 32'h24, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h99, 1'b0, 1'b1);
            @(negedge clk);
            check_outs($sformatf("full%0d", i), 1'b0, 1'b0, w7, 1'b1);
            @(posedge clk);
            #1;
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("full_release", 1'b1, 1'b1, w7, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_outs("full_drained", 1'b1, 1'b0, w7, 1'b0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a word, between clock edges.
        beat(1'b1, 32'h41, 1'b0, 1'b0);
        beat(1'b1, 32'h42, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("pre_rst.busy", WORD_W'(bus.busy_o), WORD_W'(1'b1));
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 1'b1, 1'b0, '0, 1'b0);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat(1'b1, 32'h51, 1'b0, 1'b0);
        beat(1'b1, 32'h52, 1'b0, 1'b0);
        beat(1'b1, 32'h53, 1'b0, 1'b0);
        beat(1'b1, 32'h54, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("post_rst", 1'b1, 1'b1, w8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
